mem_responder: RTL and testbench

- Memory-side responder for the datapath's MAR/MDR memory interface.
- Accepts single-word read/write requests from the control unit, applies a fixed number of wait states, and then completes the access.
- On a read, returns the word on Mdatain, which the datapath's MDR loads when Read is asserted.
- Holds a synchronous word-addressed RAM array and signals completion with a one-cycle done pulse.

---
 rtl/mem_responder.sv | 171 +++++++++++++++++
 tb/tb_mem_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM behind the MAR/MDR memory interface.
// Accepts single-word read/write requests in IDLE, inserts WAIT_STATES
// wait cycles, then completes the access with a one-cycle mem_done pulse.
//
// Ports:
//   clock     in   system clock, rising-edge
//   clear     in   asynchronous active-low reset
//   Read      in   read request (sampled in IDLE only)
//   Write     in   write request (sampled in IDLE only)
//   MAR_addr  in   word address
//   MDR_data  in   write data
//   Mdatain   out  read data, held until the next read completes
//   mem_busy  out  high from the accept edge through the done cycle
//   mem_done  out  one-cycle completion pulse
//   mem_err   out  out-of-range pulse, coincident with mem_done
//
// Optional: define MEM_RANGE_CHECK_EN to enable address range checking
// against DEPTH (out-of-range writes dropped, reads return 0, mem_err set).
// Without it DEPTH must equal 2**ADDR_W and mem_err is tied low.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] MAR_addr,
    input  logic [DATA_W-1:0] MDR_data,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAST_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] CNT_LAST = 4'(LAST_I);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Access operands: taken straight from the inputs when RESP is entered
    // directly from IDLE (WAIT_STATES=0), otherwise from the latched copy.
    logic              acc_rd;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [IDX_W-1:0]  acc_idx;
    logic              in_range;
    logic              fire;

    assign acc_rd   = (state_q == S_IDLE) ? Read : rd_q;
    assign acc_addr = (state_q == S_IDLE) ? MAR_addr : addr_q;
    assign acc_data = (state_q == S_IDLE) ? MDR_data : data_q;
    assign acc_idx  = acc_addr[IDX_W-1:0];

    // The array access happens on the edge that enters RESP.
    assign fire = (state_d == S_RESP) && (state_q != S_RESP);

`ifdef MEM_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic err_q, err_d;

    assign in_range = ({1'b0, acc_addr} < DEPTH_L);

    always_comb begin
        err_d = err_q;
        if (fire) begin
            err_d = !in_range;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err = (state_q == S_RESP) && err_q;
`else
    assign in_range = 1'b1;
    assign mem_err  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (Read || Write) begin
                    // Read wins when both are requested.
                    rd_d    = Read;
                    addr_d  = MAR_addr;
                    data_d  = MDR_data;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (fire && acc_rd) begin
            rdata_d = in_range ? mem[acc_idx] : '0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    // Array has no reset; contents survive clear.
    always_ff @(posedge clock) begin
        if (fire && !acc_rd && in_range) begin
            mem[acc_idx] <= acc_data;
        end
    end

    assign Mdatain  = rdata_q;
    assign mem_busy = (state_q != S_IDLE);
    assign mem_done = (state_q == S_RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed transactions checked against a
// transaction-level model every cycle, plus literal per-transaction checks.
module tb_mem_responder;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int WS = 2;
`ifdef MEM_RANGE_CHECK_EN
    localparam int DEPTH = 256;
`else
    localparam int DEPTH = 512;
`endif

    logic          clock;
    logic          clear;
    logic          Read;
    logic          Write;
    logic [AW-1:0] MAR_addr;
    logic [DW-1:0] MDR_data;
    logic [DW-1:0] Mdatain;
    logic          mem_busy;
    logic          mem_done;
    logic          mem_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    mem_responder #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .clock(clock),
        .clear(clear),
        .Read(Read),
        .Write(Write),
        .MAR_addr(MAR_addr),
        .MDR_data(MDR_data),
        .Mdatain(Mdatain),
        .mem_busy(mem_busy),
        .mem_done(mem_done),
        .mem_err(mem_err)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Transaction-level model: a request seen while idle occupies the
    // responder for WS+1 cycles; the last of them is the done cycle, and the
    // array effect is visible from that cycle on.
    logic [DW-1:0] mem_m [0:511];
    int            m_left;
    logic          m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_data;
    logic          m_oob;

    always @(posedge clock or negedge clear) begin : model
        logic          go;
        logic          rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        go = 1'b0;
        rd = 1'b0;
        a  = '0;
        d  = '0;
        if (!clear) begin
            m_left <= 0;
            m_data <= '0;
            m_oob  <= 1'b0;
        end else begin
            if (m_left == 0) begin
                if (Read || Write) begin
                    m_rd   <= Read;
                    m_addr <= MAR_addr;
                    m_wd   <= MDR_data;
                    m_oob  <= (int'(MAR_addr) >= DEPTH);
                    m_left <= WS + 1;
                    if (WS == 0) begin
                        go = 1'b1;
                        rd = Read;
                        a  = MAR_addr;
                        d  = MDR_data;
                    end
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 2) begin
                    go = 1'b1;
                    rd = m_rd;
                    a  = m_addr;
                    d  = m_wd;
                end
            end
            if (go) begin
                if (rd) begin
                    m_data <= (int'(a) >= DEPTH) ? '0 : mem_m[a];
                end else if (int'(a) < DEPTH) begin
                    mem_m[a] <= d;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy", {31'b0, mem_busy}, {31'b0, m_left != 0});
            chk("done", {31'b0, mem_done}, {31'b0, m_left == 1});
            chk("err", {31'b0, mem_err}, {31'b0, (m_left == 1) && m_oob});
            chk("Mdatain", Mdatain, m_data);
        end
    end

    // One request: drive it for one edge, then wait for done with a bound.
    // Checks latency, busy length, read data and error flag at done.
    // When inj is set, a write to 0x011 is pulsed during the wait cycles.
    task automatic txn(input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp, input logic exp_err,
                       input bit inj, input string nm);
        int  n;
        int  nbusy;
        bit  got;
        n     = 0;
        nbusy = 0;
        got   = 0;
        @(negedge clock);
        Read     = rd;
        Write    = wr;
        MAR_addr = a;
        MDR_data = d;
        @(posedge clock);
        #1;
        Read  = 0;
        Write = 0;
        while (!got && n < 20) begin
            @(negedge clock);
            n++;
            if (mem_busy) nbusy++;
            if (inj && n == 1) begin
                Write    = 1;
                MAR_addr = 9'h011;
                MDR_data = 32'h12345678;
            end else if (inj && n == 2) begin
                Write = 0;
            end
            if (mem_done) got = 1;
        end
        chk({nm, " latency"}, n, WS + 1);
        chk({nm, " busy cycles"}, nbusy, WS + 1);
        chk({nm, " data"}, Mdatain, exp);
        chk({nm, " err"}, {31'b0, mem_err}, {31'b0, exp_err});
    endtask

    initial begin
        clear    = 0;
        Read     = 0;
        Write    = 0;
        MAR_addr = '0;
        MDR_data = '0;
        @(posedge clock);
        chk_en = 1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset busy", {31'b0, mem_busy}, 32'd0);
        chk("reset done", {31'b0, mem_done}, 32'd0);
        chk("reset err", {31'b0, mem_err}, 32'd0);
        chk("reset data", Mdatain, 32'd0);
        @(negedge clock);
        clear = 1;

        // Preload through the interface; writes leave Mdatain at 0.
        txn(0, 1, 9'h005, 32'h00000555, 32'h0, 0, 0, "pre005");
        txn(0, 1, 9'h011, 32'h11111111, 32'h0, 0, 0, "pre011");
        txn(0, 1, 9'h012, 32'h12121212, 32'h0, 0, 0, "pre012");
        txn(0, 1, 9'h020, 32'h0000ABCD, 32'h0, 0, 0, "pre020");
        txn(0, 1, 9'h030, 32'h30303030, 32'h0, 0, 0, "pre030");
        txn(0, 1, 9'h000, 32'hA0A0A0A0, 32'h0, 0, 0, "pre000");

        txn(1, 0, 9'h005, 'x, 32'h00000555, 0, 0, "rd005");
        txn(0, 1, 9'h010, 32'hDEADBEEF, 32'h00000555, 0, 0, "wr010");
        txn(1, 0, 9'h010, 'x, 32'hDEADBEEF, 0, 0, "rd010");

        // Write pulsed while busy must be ignored.
        txn(1, 0, 9'h012, 'x, 32'h12121212, 0, 1, "rd012_inj");
        txn(1, 0, 9'h011, 'x, 32'h11111111, 0, 0, "rd011");

        // Read and Write together: read wins, word untouched.
        txn(1, 1, 9'h020, 32'hFFFFFFFF, 32'h0000ABCD, 0, 0, "rdwr020");
        txn(1, 0, 9'h020, 'x, 32'h0000ABCD, 0, 0, "rd020");

        // Abort a write mid-wait.
        @(negedge clock);
        Write    = 1;
        MAR_addr = 9'h030;
        MDR_data = 32'hCAFEF00D;
        @(posedge clock);
        #1;
        Write = 0;
        @(negedge clock);
        #2;
        clear = 0;
        #1;
        chk("abort busy", {31'b0, mem_busy}, 32'd0);
        chk("abort done", {31'b0, mem_done}, 32'd0);
        chk("abort data", Mdatain, 32'd0);
        repeat (3) @(negedge clock);
        #2;
        clear = 1;
        repeat (4) begin
            @(negedge clock);
            chk("abort no done", {31'b0, mem_done}, 32'd0);
        end
        txn(1, 0, 9'h030, 'x, 32'h30303030, 0, 0, "rd030");

`ifdef MEM_RANGE_CHECK_EN
        txn(1, 0, 9'h1FF, 'x, 32'h0, 1, 0, "rd1FF_oob");
        txn(0, 1, 9'h100, 32'hBADBAD00, 32'h0, 1, 0, "wr100_oob");
        txn(1, 0, 9'h000, 'x, 32'hA0A0A0A0, 0, 0, "rd000");
`else
        txn(1, 0, 9'h000, 'x, 32'hA0A0A0A0, 0, 0, "rd000");
`endif

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
